ram_arbiter: RTL and testbench

Two-port round-robin arbiter that shares the single-ported `ram` block between the core's instruction-fetch port and data port. Each requester issues one-cycle request pulses, and the arbiter buffers one pending request per port. It serialises accesses onto the RAM's `mem_in_type`/`mem_out_type` interface and routes each response back to its originator. A response-timeout counter converts a missing RAM `mem_ready` into an error response so neither requester can hang.

---
 rtl/ram_arbiter.sv | 175 +++++++++++++++++
 tb/tb_ram_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter sharing one single-ported RAM between the
// instruction-fetch and data ports. Each port buffers one pending request;
// a WAIT-state timer turns a missing RAM ready into an error response.

package ram_arbiter_pkg;

    typedef struct packed {
        logic        mem_valid;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic [31:0] mem_rdata;
        logic        mem_error;
        logic        mem_ready;
    } mem_out_type;

endpackage

module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int timeout = 16
) (
    input  logic        reset,
    input  logic        clock,
    input  mem_in_type  imem_in,
    output mem_out_type imem_out,
    input  mem_in_type  dmem_in,
    output mem_out_type dmem_out,
    output mem_in_type  ram_in,
    input  mem_out_type ram_out
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam logic [7:0] TIMEOUT_LAST = 8'(timeout - 1);

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic        owner;
    logic        last;
    logic [7:0]  timer;

    mem_in_type  islot;
    mem_in_type  dslot;
    mem_in_type  islot_next;
    mem_in_type  dslot_next;

    logic        ram_done;
    logic        timed_out;
    logic        done;
    logic        i_clear;
    logic        d_clear;
    logic        any_next;
    logic        pick_d;
    logic        start_issue;
    mem_out_type resp;

    // Completion happens only in WAIT: either RAM answers or the timer expires
    always_comb begin
        ram_done  = (state == WAIT) && ram_out.mem_ready;
        timed_out = (state == WAIT) && !ram_out.mem_ready && (timer == TIMEOUT_LAST);
        done      = ram_done || timed_out;
        i_clear   = done && (owner == PORT_I);
        d_clear   = done && (owner == PORT_D);
    end

    // Slot contents after this edge; a pulse is taken when the slot is free or being returned now
    always_comb begin
        islot_next = islot;
        dslot_next = dslot;
        if (i_clear) begin
            islot_next.mem_valid = 1'b0;
        end
        if (d_clear) begin
            dslot_next.mem_valid = 1'b0;
        end
        if (imem_in.mem_valid && (!islot.mem_valid || i_clear)) begin
            islot_next = imem_in;
        end
        if (dmem_in.mem_valid && (!dslot.mem_valid || d_clear)) begin
            dslot_next = dmem_in;
        end
    end

    // Round-robin pick on the post-edge slots so a same-cycle pulse can win immediately
    always_comb begin
        any_next    = islot_next.mem_valid || dslot_next.mem_valid;
        pick_d      = dslot_next.mem_valid && (!islot_next.mem_valid || (last == PORT_I));
        start_issue = ((state == IDLE) || done) && any_next;
    end

    // Next-state selection for the IDLE/ISSUE/WAIT sequencer
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (any_next) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (done) begin
                    state_next = any_next ? ISSUE : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Owner sees RAM's answer on ready, or a forced error with zero data on timeout
    always_comb begin
        resp = '0;
        if (done) begin
            resp.mem_ready = 1'b1;
            resp.mem_error = ram_done ? ram_out.mem_error : 1'b1;
            resp.mem_rdata = ram_done ? ram_out.mem_rdata : 32'h0;
        end
        imem_out = (owner == PORT_I) ? resp : '0;
        dmem_out = (owner == PORT_D) ? resp : '0;
    end

    // Sequencer state and the two pending-request slots
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            islot <= '0;
            dslot <= '0;
        end else begin
            state <= state_next;
            islot <= islot_next;
            dslot <= dslot_next;
        end
    end

    // Grant bookkeeping and the registered RAM request, valid only during ISSUE
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            owner  <= PORT_I;
            last   <= PORT_D;
            ram_in <= '0;
        end else if (start_issue) begin
            owner  <= pick_d;
            last   <= pick_d;
            ram_in <= pick_d ? dslot_next : islot_next;
        end else begin
            ram_in <= '0;
        end
    end

    // WAIT-cycle counter, restarted on every ISSUE so each access gets a full window
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timer <= 8'd0;
        end else if (state == ISSUE) begin
            timer <= 8'd0;
        end else if (state == WAIT) begin
            timer <= timer + 8'd1;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed vector table plus hand-written sequences for the
// drop, timeout and reset corner cases, against a small behavioural RAM.

module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    logic        reset;
    logic        clock;
    mem_in_type  imem_in;
    mem_out_type imem_out;
    mem_in_type  dmem_in;
    mem_out_type dmem_out;
    mem_in_type  ram_in;
    mem_out_type ram_out;
    logic        stall;

    logic [31:0] mem [16];

    int vec_count;
    int fail_count;

    typedef struct packed {
        logic        iv;
        logic [31:0] ia;
        logic [31:0] iw;
        logic [3:0]  is;
        logic        dv;
        logic [31:0] da;
        logic [31:0] dw;
        logic [3:0]  ds;
        logic        rv;
        logic [31:0] ra;
        logic [31:0] rw;
        logic [3:0]  rs;
        logic        ir;
        logic        ie;
        logic [31:0] id;
        logic        dr;
        logic        de;
        logic [31:0] dd;
    } vec_t;

    localparam int NVEC = 19;
    localparam logic        Y  = 1'b1;
    localparam logic        N  = 1'b0;
    localparam logic [31:0] Z  = 32'h0;
    localparam logic [3:0]  S0 = 4'h0;
    localparam logic [3:0]  S1 = 4'h1;

    vec_t vecs [NVEC];

    ram_arbiter #(.timeout(16)) dut (
        .reset    (reset),
        .clock    (clock),
        .imem_in  (imem_in),
        .imem_out (imem_out),
        .dmem_in  (dmem_in),
        .dmem_out (dmem_out),
        .ram_in   (ram_in),
        .ram_out  (ram_out)
    );

    // Free-running 10-unit clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // One-cycle-latency RAM; stall suppresses ready, writes return zero data
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            ram_out <= '0;
            for (int k = 0; k < 16; k++) begin
                mem[k] <= 32'h0;
            end
            mem[0] <= 32'hA0A0A0A0;
            mem[1] <= 32'hDEADBEEF;
            mem[2] <= 32'h11223344;
            mem[4] <= 32'h10101010;
        end else begin
            ram_out <= '0;
            if (ram_in.mem_valid && !stall) begin
                ram_out.mem_ready <= 1'b1;
                if (ram_in.mem_wstrb != 4'h0) begin
                    for (int b = 0; b < 4; b++) begin
                        if (ram_in.mem_wstrb[b]) begin
                            mem[ram_in.mem_addr[5:2]][8*b +: 8] <= ram_in.mem_wdata[8*b +: 8];
                        end
                    end
                end else begin
                    ram_out.mem_rdata <= mem[ram_in.mem_addr[5:2]];
                end
            end
        end
    end

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        imem_in.mem_valid = v.iv;
        imem_in.mem_addr  = v.ia;
        imem_in.mem_wdata = v.iw;
        imem_in.mem_wstrb = v.is;
        dmem_in.mem_valid = v.dv;
        dmem_in.mem_addr  = v.da;
        dmem_in.mem_wdata = v.dw;
        dmem_in.mem_wstrb = v.ds;
    endtask

    task automatic checkOutput(input int idx, input vec_t v);
        string t;
        t = $sformatf("row%0d", idx);
        compare({t, " ram_valid"}, {31'b0, ram_in.mem_valid}, {31'b0, v.rv});
        if (v.rv) begin
            compare({t, " ram_addr"}, ram_in.mem_addr, v.ra);
            compare({t, " ram_wdata"}, ram_in.mem_wdata, v.rw);
            compare({t, " ram_wstrb"}, {28'b0, ram_in.mem_wstrb}, {28'b0, v.rs});
        end
        compare({t, " imem_ready"}, {31'b0, imem_out.mem_ready}, {31'b0, v.ir});
        compare({t, " imem_error"}, {31'b0, imem_out.mem_error}, {31'b0, v.ie});
        compare({t, " imem_rdata"}, imem_out.mem_rdata, v.id);
        compare({t, " dmem_ready"}, {31'b0, dmem_out.mem_ready}, {31'b0, v.dr});
        compare({t, " dmem_error"}, {31'b0, dmem_out.mem_error}, {31'b0, v.de});
        compare({t, " dmem_rdata"}, dmem_out.mem_rdata, v.dd);
    endtask

    task automatic check_all_zero(input string tag);
        compare({tag, " ram_valid"}, {31'b0, ram_in.mem_valid}, Z);
        compare({tag, " ram_addr"}, ram_in.mem_addr, Z);
        compare({tag, " ram_wdata"}, ram_in.mem_wdata, Z);
        compare({tag, " ram_wstrb"}, {28'b0, ram_in.mem_wstrb}, Z);
        compare({tag, " imem_rdata"}, imem_out.mem_rdata, Z);
        compare({tag, " imem_err_rdy"}, {30'b0, imem_out.mem_error, imem_out.mem_ready}, Z);
        compare({tag, " dmem_rdata"}, dmem_out.mem_rdata, Z);
        compare({tag, " dmem_err_rdy"}, {30'b0, dmem_out.mem_error, dmem_out.mem_ready}, Z);
    endtask

    // Main sequence: reset, vector table, then multi-cycle corner cases
    initial begin
        int first;
        int rdy_i;
        int rdy_d;
        int issues;
        logic [31:0] cap_rdata;
        logic        cap_error;

        vec_count  = 0;
        fail_count = 0;
        reset      = 1'b1;
        stall      = 1'b0;
        imem_in    = '0;
        dmem_in    = '0;

        // Tie right after reset (imem first), then alternation under full contention
        vecs[0]  = '{Y, 32'h0, Z, S0, Y, 32'h10, Z, S0, N, Z, Z, S0, N, N, Z, N, N, Z};
        vecs[1]  = '{N, Z, Z, S0, N, Z, Z, S0, Y, 32'h0, Z, S0, N, N, Z, N, N, Z};
        vecs[2]  = '{Y, 32'h4, Z, S0, N, Z, Z, S0, N, Z, Z, S0, Y, N, 32'hA0A0A0A0, N, N, Z};
        vecs[3]  = '{N, Z, Z, S0, N, Z, Z, S0, Y, 32'h10, Z, S0, N, N, Z, N, N, Z};
        vecs[4]  = '{N, Z, Z, S0, Y, 32'h8, Z, S0, N, Z, Z, S0, N, N, Z, Y, N, 32'h10101010};
        vecs[5]  = '{N, Z, Z, S0, N, Z, Z, S0, Y, 32'h4, Z, S0, N, N, Z, N, N, Z};
        vecs[6]  = '{N, Z, Z, S0, N, Z, Z, S0, N, Z, Z, S0, Y, N, 32'hDEADBEEF, N, N, Z};
        vecs[7]  = '{N, Z, Z, S0, N, Z, Z, S0, Y, 32'h8, Z, S0, N, N, Z, N, N, Z};
        vecs[8]  = '{N, Z, Z, S0, N, Z, Z, S0, N, Z, Z, S0, N, N, Z, Y, N, 32'h11223344};
        vecs[9]  = '{N, Z, Z, S0, N, Z, Z, S0, N, Z, Z, S0, N, N, Z, N, N, Z};
        // Single uncontended read
        vecs[10] = '{Y, 32'h4, Z, S0, N, Z, Z, S0, N, Z, Z, S0, N, N, Z, N, N, Z};
        vecs[11] = '{N, Z, Z, S0, N, Z, Z, S0, Y, 32'h4, Z, S0, N, N, Z, N, N, Z};
        vecs[12] = '{N, Z, Z, S0, N, Z, Z, S0, N, Z, Z, S0, Y, N, 32'hDEADBEEF, N, N, Z};
        // Byte write then read-back issued in the write's ready cycle
        vecs[13] = '{N, Z, Z, S0, Y, 32'h8, 32'hAA, S1, N, Z, Z, S0, N, N, Z, N, N, Z};
        vecs[14] = '{N, Z, Z, S0, N, Z, Z, S0, Y, 32'h8, 32'hAA, S1, N, N, Z, N, N, Z};
        vecs[15] = '{N, Z, Z, S0, Y, 32'h8, Z, S0, N, Z, Z, S0, N, N, Z, Y, N, Z};
        vecs[16] = '{N, Z, Z, S0, N, Z, Z, S0, Y, 32'h8, Z, S0, N, N, Z, N, N, Z};
        vecs[17] = '{N, Z, Z, S0, N, Z, Z, S0, N, Z, Z, S0, N, N, Z, Y, N, 32'h112233AA};
        vecs[18] = '{N, Z, Z, S0, N, Z, Z, S0, N, Z, Z, S0, N, N, Z, N, N, Z};

        repeat (2) @(posedge clock);
        #1;
        check_all_zero("in_reset");
        @(posedge clock);
        #1;
        reset = 1'b0;
        check_all_zero("post_reset");

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            @(negedge clock);
            checkOutput(i, vecs[i]);
            @(posedge clock);
            #1;
        end
        imem_in = '0;
        dmem_in = '0;

        // Second imem pulse while the first is pending must be dropped
        rdy_i = 0;
        issues = 0;
        cap_rdata = '0;
        for (int c = 0; c < 10; c++) begin
            imem_in = '0;
            if (c == 0) begin
                imem_in.mem_valid = 1'b1;
                imem_in.mem_addr  = 32'h4;
            end else if (c == 1) begin
                imem_in.mem_valid = 1'b1;
                imem_in.mem_addr  = 32'h8;
            end
            @(negedge clock);
            if (imem_out.mem_ready) begin
                rdy_i++;
                cap_rdata = imem_out.mem_rdata;
            end
            if (ram_in.mem_valid) begin
                issues++;
            end
            @(posedge clock);
            #1;
        end
        imem_in = '0;
        compare("drop imem_ready_count", 32'(rdy_i), 32'd1);
        compare("drop ram_issue_count", 32'(issues), 32'd1);
        compare("drop imem_rdata", cap_rdata, 32'hDEADBEEF);

        // Stalled RAM: forced error response in the 16th WAIT cycle (cycle 17 after the pulse)
        stall = 1'b1;
        dmem_in.mem_valid = 1'b1;
        dmem_in.mem_addr  = 32'h8;
        first = -1;
        rdy_d = 0;
        rdy_i = 0;
        cap_rdata = 32'hFFFFFFFF;
        cap_error = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (dmem_out.mem_ready) begin
                rdy_d++;
                if (first < 0) begin
                    first     = c;
                    cap_error = dmem_out.mem_error;
                    cap_rdata = dmem_out.mem_rdata;
                end
            end
            if (imem_out.mem_ready) begin
                rdy_i++;
            end
            @(posedge clock);
            #1;
            dmem_in = '0;
        end
        compare("timeout ready_cycle", 32'(first), 32'd17);
        compare("timeout ready_count", 32'(rdy_d), 32'd1);
        compare("timeout error", {31'b0, cap_error}, 32'd1);
        compare("timeout rdata", cap_rdata, Z);
        compare("timeout imem_quiet", 32'(rdy_i), Z);

        // Arbiter is back in IDLE: a fresh pulse issues on the very next cycle
        stall = 1'b0;
        imem_in.mem_valid = 1'b1;
        imem_in.mem_addr  = 32'h4;
        @(posedge clock);
        #1;
        imem_in = '0;
        @(negedge clock);
        compare("post_timeout ram_valid", {31'b0, ram_in.mem_valid}, 32'd1);
        compare("post_timeout ram_addr", ram_in.mem_addr, 32'h4);
        @(negedge clock);
        compare("post_timeout imem_ready", {31'b0, imem_out.mem_ready}, 32'd1);
        compare("post_timeout imem_rdata", imem_out.mem_rdata, 32'hDEADBEEF);
        @(posedge clock);
        #1;

        // Reset asserted mid-WAIT while a response is on the bus
        dmem_in.mem_valid = 1'b1;
        dmem_in.mem_addr  = 32'h4;
        @(posedge clock);
        #1;
        dmem_in = '0;
        @(negedge clock);
        compare("rst_wait ram_valid", {31'b0, ram_in.mem_valid}, 32'd1);
        @(negedge clock);
        compare("rst_wait dmem_ready_before", {31'b0, dmem_out.mem_ready}, 32'd1);
        reset = 1'b1;
        #1;
        check_all_zero("rst_async");
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        rdy_i = 0;
        rdy_d = 0;
        issues = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            if (imem_out.mem_ready) rdy_i++;
            if (dmem_out.mem_ready) rdy_d++;
            if (ram_in.mem_valid) issues++;
            @(posedge clock);
        end
        compare("rst_release imem_ready_count", 32'(rdy_i), Z);
        compare("rst_release dmem_ready_count", 32'(rdy_d), Z);
        compare("rst_release ram_issue_count", 32'(issues), Z);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, fail_count);
        $finish;
    end

endmodule
